// File: rtl/rca16_word_sequencer.sv
// Multi-word adder that time-shares one 16-bit ripple-carry adder, LS word first.
// Optional macro RCA_SEQ_SUB_EN adds a subtract mode selected by port sub.

module rc_adder16 (
    output logic [15:0] sum,
    output logic        carry_out,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in
);
    logic cy;

    always_comb begin
        cy  = carry_in;
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            sum[i] = a[i] ^ b[i] ^ cy;
            cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        carry_out = cy;
    end
endmodule

module rca16_word_sequencer #(
    parameter int NUM_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [16*NUM_WORDS-1:0] a_in,
    input  logic [16*NUM_WORDS-1:0] b_in,
    input  logic                    carry_in,
`ifdef RCA_SEQ_SUB_EN
    input  logic                    sub,
`endif
    output logic                    ready,
    output logic                    busy,
    output logic                    done,
    output logic [16*NUM_WORDS-1:0] sum_out,
    output logic                    carry_out
);
    localparam int W     = 16 * NUM_WORDS;
    localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     op_a, op_b, sum_reg;
    logic             carry_reg, cout_reg;
    logic [CNT_W+3:0] word_base;
    logic [15:0]      add_sum;
    logic             add_cout;

    assign word_base = {cnt, 4'b0000};

    rc_adder16 u_adder (
        .sum       (add_sum),
        .carry_out (add_cout),
        .a         (op_a[word_base +: 16]),
        .b         (op_b[word_base +: 16]),
        .carry_in  (carry_reg)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture in IDLE; one result word and the inter-word carry per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt  <= '0;
                        op_a <= a_in;
`ifdef RCA_SEQ_SUB_EN
                        op_b      <= sub ? ~b_in : b_in;
                        carry_reg <= sub ? 1'b1 : carry_in;
`else
                        op_b      <= b_in;
                        carry_reg <= carry_in;
`endif
                    end
                end
                RUN: begin
                    sum_reg[word_base +: 16] <= add_sum;
                    carry_reg                <= add_cout;
                    if (cnt == LAST) cout_reg <= add_cout;
                    else             cnt      <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign sum_out   = sum_reg;
    assign carry_out = cout_reg;
endmodule

// File: tb/tb_rca16_word_sequencer.sv
// Randomized self-checking bench for rca16_word_sequencer against a plain-arithmetic model.

module tb_rca16_word_sequencer;
    localparam int NW = 4;
    localparam int W  = 16 * NW;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         carry_in;
`ifdef RCA_SEQ_SUB_EN
    logic         sub;
`endif
    logic         ready, busy, done;
    logic [W-1:0] sum_out;
    logic         carry_out;

    int n_cmp = 0;
    int n_bad = 0;

    rca16_word_sequencer #(.NUM_WORDS(NW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .carry_in  (carry_in),
`ifdef RCA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic cin, input logic sb);
        logic [W:0] r;
        if (sb) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        return r;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sb, input logic noisy);
        logic [W:0] exp;
        exp = ref_result(a, b, cin, sb);
        a_in     = a;
        b_in     = b;
        carry_in = cin;
`ifdef RCA_SEQ_SUB_EN
        sub      = sb;
`endif
        start    = 1'b1;
        step();
        for (int i = 0; i < NW; i++) begin
            check_val("busy_run", {{W{1'b0}}, busy}, 1);
            check_val("done_run", {{W{1'b0}}, done}, 0);
            if (noisy) begin
                start    = 1'($urandom % 2);
                a_in     = {$urandom, $urandom};
                b_in     = {$urandom, $urandom};
                carry_in = 1'($urandom % 2);
`ifdef RCA_SEQ_SUB_EN
                sub      = 1'($urandom % 2);
`endif
            end else begin
                start = 1'b0;
            end
            step();
        end
        check_val("done_pulse", {{W{1'b0}}, done}, 1);
        check_val("busy_done", {{W{1'b0}}, busy}, 0);
        check_val("ready_done", {{W{1'b0}}, ready}, 0);
        check_val("sum", {1'b0, sum_out}, {1'b0, exp[W-1:0]});
        check_val("carry_out", {{W{1'b0}}, carry_out}, {{W{1'b0}}, exp[W]});
        if (noisy) begin
            start = 1'b1;
            a_in  = {$urandom, $urandom};
            b_in  = {$urandom, $urandom};
        end
        step();
        start = 1'b0;
        check_val("ready_after", {{W{1'b0}}, ready}, 1);
        check_val("done_after", {{W{1'b0}}, done}, 0);
        check_val("sum_held", {1'b0, sum_out}, {1'b0, exp[W-1:0]});
        check_val("cout_held", {{W{1'b0}}, carry_out}, {{W{1'b0}}, exp[W]});
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        a_in     = '0;
        b_in     = '0;
        carry_in = 1'b0;
`ifdef RCA_SEQ_SUB_EN
        sub      = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
        check_val("rst_ready", {{W{1'b0}}, ready}, 1);
        check_val("rst_busy", {{W{1'b0}}, busy}, 0);
        check_val("rst_done", {{W{1'b0}}, done}, 0);
        check_val("rst_sum", {1'b0, sum_out}, 0);
        check_val("rst_cout", {{W{1'b0}}, carry_out}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("idle_ready", {{W{1'b0}}, ready}, 1);
            check_val("idle_busy", {{W{1'b0}}, busy}, 0);
        end

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        run_op(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0, 1'b0);
        run_op(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0, 1'b1);

        // Abort mid-RUN: no done pulse and cleared outputs afterwards.
        a_in     = 64'hFFFF_FFFF_FFFF_FFFF;
        b_in     = 64'h1;
        carry_in = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("abort_ready", {{W{1'b0}}, ready}, 1);
        check_val("abort_busy", {{W{1'b0}}, busy}, 0);
        check_val("abort_done", {{W{1'b0}}, done}, 0);
        check_val("abort_sum", {1'b0, sum_out}, 0);
        check_val("abort_cout", {{W{1'b0}}, carry_out}, 0);
        for (int i = 0; i < NW + 2; i++) begin
            step();
            check_val("abort_no_done", {{W{1'b0}}, done}, 0);
        end
        run_op(64'h7, 64'h9, 1'b0, 1'b0, 1'b0);

`ifdef RCA_SEQ_SUB_EN
        run_op(64'h5, 64'h7, 1'b1, 1'b1, 1'b0);
        run_op(64'h7, 64'h5, 1'b0, 1'b1, 1'b0);
`endif

        for (int n = 0; n < 25; n++) begin
            logic [W-1:0] ra, rb;
            logic         sb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (n % 5 == 0) rb = ~ra;
`ifdef RCA_SEQ_SUB_EN
            sb = 1'($urandom % 2);
`else
            sb = 1'b0;
`endif
            run_op(ra, rb, 1'($urandom % 2), sb, 1'($urandom % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
